// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and slice width.
package sub_defs;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_nibble_sub.sv
// Combinational 4-bit borrow-chain slice, reused once per clock by the serial subtractor.
module nibble_sub
   import sub_defs::*;
(
   input  logic [NIB_W-1:0] A,
   input  logic [NIB_W-1:0] B,
   input  logic             bi,
   output logic [NIB_W-1:0] d,
   output logic             bo
);

   logic [NIB_W:0] w_chain;

   assign w_chain[0] = bi;

   for (genvar g = 0; g < NIB_W; g++) begin : g_bit
      assign d[g]         = A[g] ^ B[g] ^ w_chain[g];
      assign w_chain[g+1] = (~A[g] & B[g]) | (~(A[g] ^ B[g]) & w_chain[g]);
   end

   assign bo = w_chain[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// WIDTH-bit unsigned subtractor that processes one nibble per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_subtractor
   import sub_defs::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   localparam int NNIB = WIDTH / NIB_W;
   localparam int IW   = $clog2(NNIB);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_brw;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_zero;

   logic [NIB_W-1:0] w_d;
   logic             w_bo;
   logic             w_last;
   logic [WIDTH-1:0] w_fullDiff;

   // Operand copies shift right each cycle so the slice always sees the current nibble in bits [3:0].
   nibble_sub u_slice (
      .A  (r_a[NIB_W-1:0]),
      .B  (r_b[NIB_W-1:0]),
      .bi (r_brw),
      .d  (w_d),
      .bo (w_bo)
   );

   assign w_last     = (r_idx == IW'(NNIB - 1));
   assign w_fullDiff = {w_d, r_diff[WIDTH-NIB_W-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Loading bin into the borrow register at accept means nibble 0 never sees a stale borrow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_brw  <= 1'b0;
         r_idx  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
         r_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_brw  <= bin;
                  r_idx  <= '0;
                  r_diff <= '0;
               end
            end
            ST_RUN: begin
               r_diff[r_idx*NIB_W +: NIB_W] <= w_d;
               r_brw <= w_bo;
               r_a   <= r_a >> NIB_W;
               r_b   <= r_b >> NIB_W;
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_bout <= w_bo;
                  r_zero <= (w_fullDiff == '0);
                  r_idx  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;
   assign zero = r_zero;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: directed corner cases plus randomized operations against an arithmetic model.
module tb_nibble_serial_subtractor;

   localparam int WIDTH = 16;
   localparam int NNIB  = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;

   int checkCount = 0;
   int errorCount = 0;

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Runs one operation end to end; holdCycles keeps out_ready low in DONE while junk operands are offered.
   task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                input logic opBin, input int holdCycles);
      int             wait_n;
      int             lat;
      int             ea;
      int             eb;
      logic [WIDTH-1:0] expDiff;
      logic           expBout;
      logic           expZero;

      ea      = int'(opA);
      eb      = int'(opB) + int'(opBin);
      expDiff = WIDTH'(ea - eb);
      expBout = (ea < eb);
      expZero = (expDiff == '0);

      @(negedge clk);
      wait_n = 0;
      while (!in_ready && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);

      a        = opA;
      b        = opB;
      bin      = opBin;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      bin      = 1'($urandom);

      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(NNIB));
      checkOutput("diff", 32'(diff), 32'(expDiff));
      checkOutput("bout", 32'(bout), 32'(expBout));
      checkOutput("zero", 32'(zero), 32'(expZero));

      for (int h = 0; h < holdCycles; h++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         a         = WIDTH'($urandom);
         b         = WIDTH'($urandom);
         @(negedge clk);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
         checkOutput("hold_diff", 32'(diff), 32'(expDiff));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("release_out_valid", 32'(out_valid), 32'd0);
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_diff", 32'(diff), 32'd0);
      checkOutput("rst_bout", 32'(bout), 32'd0);
      checkOutput("rst_zero", 32'(zero), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      applyStimulus(16'h1234, 16'h0234, 1'b0, 0);
      applyStimulus(16'h1000, 16'h0001, 1'b0, 0);
      applyStimulus(16'h0000, 16'h0000, 1'b1, 0);
      applyStimulus(16'hABCD, 16'hABCD, 1'b0, 0);
      applyStimulus(16'h8765, 16'h1111, 1'b1, 5);

      // Abort an operation after two nibbles; outputs must clear at once.
      @(negedge clk);
      a        = 16'hFFFF;
      b        = 16'h0001;
      bin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_diff", 32'(diff), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(16'h0005, 16'h0003, 1'b0, 0);

      for (int n = 0; n < 25; n++) begin
         applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
      applyStimulus(16'h0000, 16'hFFFF, 1'b1, 0);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
